// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the fetch-queue entry type
// for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order circular buffer of fetched words.
// Entries are allocated at issue and filled on response.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int QDEPTH = 2,
  localparam int AW     = $clog2(QDEPTH),
  localparam int CW     = AW + 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_alloc,
  input  logic [31:0]  i_alloc_pc,
  input  logic         i_fill,
  input  logic [31:0]  i_fill_inst,
  input  logic         i_pop,
  input  logic         i_clear,
  output fetch_entry_t o_head,
  output logic [CW-1:0] o_count,
  output logic [CW-1:0] o_unfilled
);

  fetch_entry_t  r_q [QDEPTH];
  logic [CW-1:0] r_head;
  logic [CW-1:0] r_fill;
  logic [CW-1:0] r_alloc;

  logic [AW-1:0] w_hi;
  logic [AW-1:0] w_fi;
  logic [AW-1:0] w_ai;

  assign w_hi = r_head[AW-1:0];
  assign w_fi = r_fill[AW-1:0];
  assign w_ai = r_alloc[AW-1:0];

  assign o_head     = r_q[w_hi];
  assign o_count    = r_alloc - r_head;
  assign o_unfilled = r_alloc - r_fill;

  // pointer and entry update; clear wins over alloc/fill/pop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_fill  <= '0;
      r_alloc <= '0;
      for (int i = 0; i < QDEPTH; i++)
        r_q[i] <= '0;
    end else if (i_clear) begin
      r_head  <= '0;
      r_fill  <= '0;
      r_alloc <= '0;
      for (int i = 0; i < QDEPTH; i++)
        r_q[i].filled <= 1'b0;
    end else begin
      if (i_alloc) begin
        r_q[w_ai].pc     <= i_alloc_pc;
        r_q[w_ai].inst   <= NOP;
        r_q[w_ai].filled <= 1'b0;
        r_alloc          <= r_alloc + CW'(1);
      end
      if (i_fill) begin
        r_q[w_fi].inst   <= i_fill_inst;
        r_q[w_fi].filled <= 1'b1;
        r_fill           <= r_fill + CW'(1);
      end
      if (i_pop) begin
        r_q[w_hi].filled <= 1'b0;
        r_head           <= r_head + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, memory issue, wrong-path discard, output.
// Define FETCH_PERF_EN to add StallCycles/BubbleCycles.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        StallD,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemRdy,
  input  logic        ImemValid,
  input  logic [31:0] ImemData,
  output logic        InstValid,
  output logic [31:0] Inst_out,
  output logic [31:0] PC_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] BubbleCycles
`endif
);

  localparam int CW  = $clog2(QDEPTH) + 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] LP_QD = CW1'(QDEPTH);

  logic [31:0]   r_pc;
  logic [CW-1:0] r_discard;

  fetch_entry_t  w_head;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_unfilled;
  logic          w_valid;
  logic          w_pop;
  logic [CW:0]   w_occ;
  logic          w_fire;
  logic          w_fill;
  logic          w_drop;
  logic [CW-1:0] w_outst;
  logic [CW-1:0] w_redir_disc;
  logic [31:0]   w_tgt;

  assign w_valid = w_head.filled;
  assign w_pop   = w_valid && !StallD && !Redirect;

  // an entry freed by this cycle's pop can be reused at once
  assign w_occ = CW1'(w_count) + CW1'(r_discard)
               - CW1'(w_pop);

  assign ImemReq  = Reset && !Redirect && (w_occ < LP_QD);
  assign ImemAddr = r_pc;
  assign w_fire   = ImemReq && ImemRdy;

  assign w_fill = ImemValid && !Redirect
               && (r_discard == '0) && (w_unfilled != '0);
  assign w_drop = ImemValid && !Redirect
               && (r_discard != '0);

  // reads still in flight; the one landing now is consumed
  assign w_outst      = r_discard + w_unfilled;
  assign w_redir_disc = (ImemValid && (w_outst != '0))
                      ? w_outst - CW'(1) : w_outst;

  assign w_tgt = RedirectPC & 32'hFFFF_FFFC;

  assign InstValid = w_valid;
  assign Inst_out  = w_valid ? w_head.inst : NOP;
  assign PC_out    = w_valid ? w_head.pc   : 32'h0;

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .i_clk       (clk),
    .i_rst_n     (Reset),
    .i_alloc     (w_fire),
    .i_alloc_pc  (r_pc),
    .i_fill      (w_fill),
    .i_fill_inst (ImemData),
    .i_pop       (w_pop),
    .i_clear     (Redirect),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_unfilled  (w_unfilled)
  );

  // fetch PC: redirect target, else advance on handshake
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset)
      r_pc <= {RESET_PC[31:2], 2'b00};
    else if (Redirect)
      r_pc <= w_tgt;
    else if (w_fire)
      r_pc <= r_pc + 32'd4;
  end

  // count of wrong-path responses still to be dropped
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset)
      r_discard <= '0;
    else if (Redirect)
      r_discard <= w_redir_disc;
    else if (w_drop)
      r_discard <= r_discard - CW'(1);
  end

  a_no_orphan_resp: assert property (
    @(posedge clk) disable iff (!Reset)
    !(ImemValid && (w_unfilled == '0) && (r_discard == '0))
  );

`ifdef FETCH_PERF_EN
  logic r_seen;

  // stall/bubble counters; bubbles count once fetch has delivered
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_seen       <= 1'b0;
      StallCycles  <= 32'h0;
      BubbleCycles <= 32'h0;
    end else begin
      if (w_valid)
        r_seen <= 1'b1;
      if (w_valid && StallD)
        StallCycles <= StallCycles + 32'd1;
      if (r_seen && !w_valid && !StallD)
        BubbleCycles <= BubbleCycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed tests for fetch_unit with an
// in-order memory model of configurable latency.
module tb_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        StallD = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = 32'h0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemRdy = 1'b1;
  logic        ImemValid = 1'b0;
  logic [31:0] ImemData = 32'h0;
  logic        InstValid;
  logic [31:0] Inst_out;
  logic [31:0] PC_out;

  logic        StallD2 = 1'b0;
  logic        Redirect2 = 1'b0;
  logic [31:0] RedirectPC2 = 32'h0;
  logic        ImemReq2;
  logic [31:0] ImemAddr2;
  logic        ImemRdy2 = 1'b1;
  logic        ImemValid2 = 1'b0;
  logic [31:0] ImemData2 = 32'h0;
  logic        InstValid2;
  logic [31:0] Inst_out2;
  logic [31:0] PC_out2;

`ifdef FETCH_PERF_EN
  logic [31:0] StallCycles, BubbleCycles;
  logic [31:0] StallCycles2, BubbleCycles2;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 1;
  logic [31:0] q_addr[$];
  int          q_due[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .Reset      (Reset),
    .StallD     (StallD),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .ImemReq    (ImemReq),
    .ImemAddr   (ImemAddr),
    .ImemRdy    (ImemRdy),
    .ImemValid  (ImemValid),
    .ImemData   (ImemData),
    .InstValid  (InstValid),
    .Inst_out   (Inst_out),
    .PC_out     (PC_out)
`ifdef FETCH_PERF_EN
    ,
    .StallCycles  (StallCycles),
    .BubbleCycles (BubbleCycles)
`endif
  );

  fetch_unit #(
    .RESET_PC (32'hFFFF_FFF8)
  ) dut2 (
    .clk        (clk),
    .Reset      (Reset),
    .StallD     (StallD2),
    .Redirect   (Redirect2),
    .RedirectPC (RedirectPC2),
    .ImemReq    (ImemReq2),
    .ImemAddr   (ImemAddr2),
    .ImemRdy    (ImemRdy2),
    .ImemValid  (ImemValid2),
    .ImemData   (ImemData2),
    .InstValid  (InstValid2),
    .Inst_out   (Inst_out2),
    .PC_out     (PC_out2)
`ifdef FETCH_PERF_EN
    ,
    .StallCycles  (StallCycles2),
    .BubbleCycles (BubbleCycles2)
`endif
  );

  // one clock; memory models react just after the edge
  task automatic step();
    logic f, f2;
    logic [31:0] a, a2;
    #1;
    f  = ImemReq && ImemRdy;
    a  = ImemAddr;
    f2 = ImemReq2 && ImemRdy2;
    a2 = ImemAddr2;
    @(posedge clk);
    #1;
    cyc++;
    ImemValid  = 1'b0;
    ImemData   = 32'h0;
    ImemValid2 = 1'b0;
    ImemData2  = 32'h0;
    if (!Reset) begin
      q_addr.delete();
      q_due.delete();
    end else begin
      if (f) begin
        q_addr.push_back(a);
        q_due.push_back(cyc - 1 + lat);
      end
      if (q_due.size() > 0 && q_due[0] == cyc) begin
        ImemValid = 1'b1;
        ImemData  = q_addr[0] ^ K;
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      ImemValid2 = f2;
      ImemData2  = a2 ^ K;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    StallD = 1'b0;
    Redirect = 1'b0;
    RedirectPC = 32'h0;
    ImemRdy = 1'b1;
    step();
    step();
    Reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    step();
    step();
    checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", ImemReq); end
    checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", InstValid); end
    checks++; if (Inst_out !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h exp 0", Inst_out); end
    checks++; if (PC_out !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h exp 0", PC_out); end
    checks++; if (ImemAddr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h exp 0", ImemAddr); end
    Reset = 1'b1;
    #1;
    checks++; if (ImemReq !== 1'b1) begin errors++; $display("FAIL first_req: got %b exp 1", ImemReq); end
    step();
    step();
    step();
    checks++; if (InstValid !== 1'b1) begin errors++; $display("FAIL pre_mid_rst_valid: got %b exp 1", InstValid); end
    Reset = 1'b0;
    #1;
    checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b exp 0", InstValid); end
    checks++; if (PC_out !== 32'h0) begin errors++; $display("FAIL mid_rst_pc: got %h exp 0", PC_out); end
    checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL mid_rst_req: got %b exp 0", ImemReq); end
    checks++; if (ImemAddr !== 32'h0) begin errors++; $display("FAIL mid_rst_addr: got %h exp 0", ImemAddr); end
  endtask

  task automatic test_basic();
    logic [31:0] ea, ep;
    lat = 1;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      ea = 32'(4 * (k - 1));
      checks++; if (ImemAddr !== ea) begin errors++; $display("FAIL basic_addr c%0d: got %h exp %h", k, ImemAddr, ea); end
      if (k >= 3) begin
        ep = 32'(4 * (k - 3));
        checks++; if (InstValid !== 1'b1) begin errors++; $display("FAIL basic_valid c%0d: got %b exp 1", k, InstValid); end
        checks++; if (PC_out !== ep) begin errors++; $display("FAIL basic_pc c%0d: got %h exp %h", k, PC_out, ep); end
        checks++; if (Inst_out !== (ep ^ K)) begin errors++; $display("FAIL basic_inst c%0d: got %h exp %h", k, Inst_out, ep ^ K); end
      end else begin
        checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL basic_novalid c%0d: got %b exp 0", k, InstValid); end
      end
      step();
    end
  endtask

  task automatic test_stall();
    logic [31:0] ep;
    lat = 1;
    do_reset();
    step();
    step();
    step();
    StallD = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (InstValid !== 1'b1) begin errors++; $display("FAIL stall_valid %0d: got %b exp 1", i, InstValid); end
      checks++; if (PC_out !== 32'h4) begin errors++; $display("FAIL stall_pc %0d: got %h exp 4", i, PC_out); end
      checks++; if (Inst_out !== (32'h4 ^ K)) begin errors++; $display("FAIL stall_inst %0d: got %h exp %h", i, Inst_out, 32'h4 ^ K); end
      checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL stall_req %0d: got %b exp 0", i, ImemReq); end
      step();
    end
    StallD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ep = 32'(4 + 4 * i);
      checks++; if (InstValid !== 1'b1) begin errors++; $display("FAIL resume_valid %0d: got %b exp 1", i, InstValid); end
      checks++; if (PC_out !== ep) begin errors++; $display("FAIL resume_pc %0d: got %h exp %h", i, PC_out, ep); end
      step();
    end
  endtask

  task automatic test_redirect_stale();
    int n;
    lat = 3;
    do_reset();
    step();
    step();
    #1;
    checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL l3_full_req: got %b exp 0", ImemReq); end
    Redirect = 1'b1;
    RedirectPC = 32'h0000_0103;
    step();
    Redirect = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      #1;
      checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL l3_bubble c%0d: got %b exp 0", c, InstValid); end
      if (c == 4) begin
        checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL l3_disc_block: got %b exp 0", ImemReq); end
      end
      if (c == 5) begin
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h100) begin errors++; $display("FAIL l3_tgt_req: got %b/%h exp 1/00000100", ImemReq, ImemAddr); end
      end
      step();
    end
    checks++; if (InstValid !== 1'b1 || PC_out !== 32'h100) begin errors++; $display("FAIL l3_tgt_pc: got %b/%h exp 1/00000100", InstValid, PC_out); end
    checks++; if (Inst_out !== (32'h100 ^ K)) begin errors++; $display("FAIL l3_tgt_inst: got %h exp %h", Inst_out, 32'h100 ^ K); end
    step();
    checks++; if (InstValid !== 1'b1 || PC_out !== 32'h104) begin errors++; $display("FAIL l3_pc104: got %b/%h exp 1/00000104", InstValid, PC_out); end
    step();
    n = 0;
    while (!InstValid && n < 10) begin
      step();
      n++;
    end
    checks++; if (InstValid !== 1'b1 || PC_out !== 32'h108) begin errors++; $display("FAIL l3_pc108: got %b/%h exp 1/00000108", InstValid, PC_out); end
    lat = 1;
  endtask

  task automatic test_redirect_pop();
    lat = 1;
    do_reset();
    step();
    step();
    step();
    checks++; if (InstValid !== 1'b1 || ImemValid !== 1'b1) begin errors++; $display("FAIL rp_setup: got %b/%b exp 1/1", InstValid, ImemValid); end
    Redirect = 1'b1;
    RedirectPC = 32'h0000_0200;
    step();
    Redirect = 1'b0;
    #1;
    checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL rp_n1_valid: got %b exp 0", InstValid); end
    checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h200) begin errors++; $display("FAIL rp_n1_req: got %b/%h exp 1/00000200", ImemReq, ImemAddr); end
    step();
    checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL rp_n2_valid: got %b exp 0", InstValid); end
    step();
    checks++; if (InstValid !== 1'b1 || PC_out !== 32'h200) begin errors++; $display("FAIL rp_n3_pc: got %b/%h exp 1/00000200", InstValid, PC_out); end
    checks++; if (Inst_out !== (32'h200 ^ K)) begin errors++; $display("FAIL rp_n3_inst: got %h exp %h", Inst_out, 32'h200 ^ K); end
    step();
    checks++; if (InstValid !== 1'b1 || PC_out !== 32'h204) begin errors++; $display("FAIL rp_n4_pc: got %b/%h exp 1/00000204", InstValid, PC_out); end
  endtask

  task automatic test_reset_pc_wrap();
    lat = 1;
    do_reset();
    checks++; if (ImemAddr2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_addr0: got %h exp fffffff8", ImemAddr2); end
    step();
    step();
    checks++; if (ImemAddr2 !== 32'h0) begin errors++; $display("FAIL wrap_addr2: got %h exp 0", ImemAddr2); end
    checks++; if (InstValid2 !== 1'b1 || PC_out2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_pc0: got %b/%h exp 1/fffffff8", InstValid2, PC_out2); end
    step();
    checks++; if (InstValid2 !== 1'b1 || PC_out2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc1: got %b/%h exp 1/fffffffc", InstValid2, PC_out2); end
    step();
    checks++; if (InstValid2 !== 1'b1 || PC_out2 !== 32'h0) begin errors++; $display("FAIL wrap_pc2: got %b/%h exp 1/00000000", InstValid2, PC_out2); end
    checks++; if (Inst_out2 !== K) begin errors++; $display("FAIL wrap_inst2: got %h exp %h", Inst_out2, K); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    lat = 1;
    do_reset();
    step();
    step();
    step();
    StallD = 1'b1;
    for (int i = 0; i < 4; i++) step();
    StallD = 1'b0;
    Redirect = 1'b1;
    RedirectPC = 32'h0000_0300;
    step();
    Redirect = 1'b0;
    ImemRdy = 1'b0;
    step();
    ImemRdy = 1'b1;
    step();
    step();
    checks++; if (InstValid !== 1'b1 || PC_out !== 32'h300) begin errors++; $display("FAIL perf_tgt: got %b/%h exp 1/00000300", InstValid, PC_out); end
    checks++; if (StallCycles !== 32'd4) begin errors++; $display("FAIL perf_stall: got %0d exp 4", StallCycles); end
    checks++; if (BubbleCycles !== 32'd3) begin errors++; $display("FAIL perf_bubble: got %0d exp 3", BubbleCycles); end
    Reset = 1'b0;
    #1;
    checks++; if (StallCycles !== 32'd0) begin errors++; $display("FAIL perf_stall_rst: got %0d exp 0", StallCycles); end
    checks++; if (BubbleCycles !== 32'd0) begin errors++; $display("FAIL perf_bubble_rst: got %0d exp 0", BubbleCycles); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_stale();
    test_redirect_pop();
    test_reset_pc_wrap();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the fetch/decode pipeline register. Owns the program counter, issues in-order word reads to instruction memory through a ready/valid handshake, and buffers returned words with their PCs in a small queue. Each cycle it presents one instruction and its PC, or a NOP bubble, to the fetch/decode register. Handles decode-stage stalls and branch/jump redirects, including discarding in-flight responses from the wrong path.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- QDEPTH, 2, fetch-queue entries (power of two, ≥2); also the maximum number of outstanding memory reads

Ports:
- clk  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- StallD  in  1  decode stall; current Inst_out/PC_out are held and not consumed
- Redirect  in  1  taken branch/jump resolved in decode (same pulse as the pipeline-register Flush)
- RedirectPC  in  32  redirect target; bits [1:0] ignored and forced to 00
- ImemReq  out  1  read request valid
- ImemAddr  out  32  word-aligned read address
- ImemRdy  in  1  memory accepts the request this cycle
- ImemValid  in  1  read data valid; responses return in order, latency ≥1
- ImemData  in  32  read data
- InstValid  out  1  Inst_out/PC_out carry a real instruction
- Inst_out  out  32  instruction to fetch/decode register; 32'h0 (NOP) when InstValid=0
- PC_out  out  32  PC of Inst_out; 0 when InstValid=0

## Operation
- Queue entry: {pc[31:0], inst[31:0], filled}. Entries are allocated in order at issue time and filled in order when responses arrive.
- Issue:
  - ImemReq=1 when Reset is deasserted, Redirect=0, and allocated entries < QDEPTH.
  - The handshake fires on ImemReq && ImemRdy. Firing allocates an entry with pc=fetchPC and sets fetchPC += 4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0).
  - ImemAddr = fetchPC at all times.
- Response: on ImemValid with discard count = 0, write ImemData into the oldest allocated, unfilled entry and set filled.
- Output:
  - InstValid = head entry filled; Inst_out/PC_out = head contents, otherwise 0/0.
  - The head is popped on InstValid && !StallD.
- Redirect (takes priority over everything):
  - No issue in the Redirect cycle.
  - fetchPC ← {RedirectPC[31:2],2'b00}.
  - All entries are cleared, including a head being popped in the same cycle.
  - discard ← number of allocated, unfilled entries, minus 1 if ImemValid is asserted this cycle. The response arriving in the Redirect cycle is itself dropped.
- Discard: while discard > 0, each ImemValid decrements discard and its data is dropped. The discard counter is clog2(QDEPTH+1) bits wide.
- Issue is additionally blocked while allocated + discard ≥ QDEPTH. This bounds outstanding reads to QDEPTH.
- ImemValid with nothing allocated and discard = 0 is a protocol error. The response is ignored; the error is checked by assertion only.

## Timing
- Reset values: fetchPC=RESET_PC, queue empty, discard=0, ImemReq=0, InstValid=0, Inst_out=0, PC_out=0, perf counters 0.
- First request is in the first cycle after Reset deasserts.
- A request issued at cycle t whose response arrives at t+L gives InstValid=1 at t+L+1. Responses are registered; there is no bypass.
- Redirect at cycle N:
  - Target request at N+1.
  - With L=1, the target instruction is valid at N+3.
  - InstValid=0 from N+1 until then.
- Steady state with L=1, ImemRdy=1, no stall: one instruction per cycle.
- StallD held: outputs are stable. The queue fills to QDEPTH, then ImemReq drops.
- Reset asserted mid-operation: all state returns to reset values immediately. Responses arriving after reset are not expected.

## Configuration
- FETCH_PERF_EN defined:
  - Adds output ports StallCycles[31:0] (counts cycles with InstValid && StallD) and BubbleCycles[31:0] (counts cycles with !InstValid && !StallD).
  - Both are cleared by reset and wrap at 2^32.
- FETCH_PERF_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package fetch_pkg holds:
  - the NOP constant 32'h0
  - the default RESET_PC
  - the fetch-queue entry struct
- Sub-module fetch_queue holds:
  - the circular buffer: head, alloc and fill pointers; filled bits
  - allocate, fill, pop and clear operations
- fetch_unit holds the PC, the issue logic, the discard counter and the perf counters.

## Test plan
- Reset, then ImemRdy=1 with L=1 memory returning data = addr ^ 32'hA5A5_A5A5 → ImemAddr sequence 0,4,8…; InstValid from the 3rd cycle after reset; PC_out/Inst_out pairs match.
- StallD=1 for 5 cycles with QDEPTH=2 → Inst_out/PC_out constant; ImemReq=0 after 2 allocations; resumes with no lost or duplicated PC.
- L=3 memory; Redirect to 32'h0000_0100 while 2 reads are outstanding → both stale responses dropped; next valid PC_out=0x100; no 0x108-before-0x104 reordering.
- Redirect in the same cycle as ImemValid and as a head pop with StallD=0 → popped entry and arriving data dropped; discard equals remaining outstanding reads.
- RESET_PC=32'hFFFF_FFF8, no stall → PC_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- FETCH_PERF_EN defined: 4 stall cycles plus 3 redirect bubble cycles → StallCycles=4, BubbleCycles=3 (bubbles counted from first-fetch validity); Reset mid-run clears both to 0.
